// File: rtl/time_set_pkg.sv
// Shared state encoding, field moduli and wrap-around helpers for the time-set controller.
package time_set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2,
        ST_SEC  = 2'd3
    } state_t;

    localparam int MIN_MOD = 60;
    localparam int SEC_MOD = 60;

    // Out-of-range values also land on 0 so a corrupt field heals on the next step.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input int modulus);
        if (int'(value) >= modulus - 1) begin
            return 6'd0;
        end
        return value + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] value, input int modulus);
        if (value == 6'd0) begin
            return 6'(modulus - 1);
        end
        return value - 6'd1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_button_repeat.sv
// Press detection plus hold-to-repeat for one button; step is asserted on the cycle an action applies.
module button_repeat #(
    parameter int DELAY  = 50_000_000,
    parameter int PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic clear,
    output logic step
);

    localparam int CW = $clog2(((DELAY > PERIOD) ? DELAY : PERIOD) + 1);

    logic          hist;
    logic          armed;
    logic          repeating;
    logic [CW-1:0] cnt;
    logic          press;
    logic          due;

    assign press = btn & ~hist;
    assign due   = armed & (repeating ? (cnt == CW'(PERIOD)) : (cnt == CW'(DELAY)));
    assign step  = btn & ~clear & (press | due);

    // Only a genuine press arms repeating; a clear disarms until the button is released and pressed again.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist      <= 1'b1;
            armed     <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
        end else begin
            hist <= btn;
            if (!btn || clear) begin
                armed     <= 1'b0;
                repeating <= 1'b0;
                cnt       <= '0;
            end else if (press) begin
                armed     <= 1'b1;
                repeating <= 1'b0;
                cnt       <= CW'(1);
            end else if (due) begin
                repeating <= 1'b1;
                cnt       <= CW'(1);
            end else if (armed) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Set/up/down editor for the wall clock fields: snapshots the running time, edits it, then commits or times out.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int HOURS_MOD      = 24,
    parameter int ENABLE_SEC     = 1,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_PERIOD  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int HW             = $clog2(HOURS_MOD)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set,
    input  logic          up,
    input  logic          down,
    input  logic [HW-1:0] cur_hours,
    input  logic [5:0]    cur_minutes,
    input  logic [5:0]    cur_seconds,
    output logic [HW-1:0] hours,
    output logic [5:0]    minutes,
    output logic [5:0]    seconds,
    output logic          propagate,
    output logic          timeout,
    output logic [1:0]    currentState
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state;
    logic          setHist;
    logic          setPress;
    logic          buttonClear;
    logic          upStep;
    logic          downStep;
    logic          activity;
    logic          timeoutHit;
    logic [TW-1:0] idleCnt;
    logic [HW-1:0] shadowHours;
    logic [5:0]    shadowMinutes;
    logic [5:0]    shadowSeconds;
    logic [5:0]    curSec;

    assign setPress     = set & ~setHist;
    assign buttonClear  = setPress | (up & down);
    assign activity     = setPress | upStep | downStep;
    assign curSec       = (ENABLE_SEC != 0) ? cur_seconds : 6'd0;
    assign currentState = state;
    assign timeoutHit   = (TIMEOUT_CYCLES != 0) && (state != ST_IDLE) && !activity
                          && (idleCnt == TW'(TIMEOUT_CYCLES - 1));

    button_repeat #(.DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) upRepeat (
        .clk   (clk),
        .reset (reset),
        .btn   (up),
        .clear (buttonClear),
        .step  (upStep)
    );

    button_repeat #(.DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) downRepeat (
        .clk   (clk),
        .reset (reset),
        .btn   (down),
        .clear (buttonClear),
        .step  (downStep)
    );

    // Priority inside an edit state: set press, then idle abort, then a field step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            setHist       <= 1'b1;
            hours         <= '0;
            minutes       <= '0;
            seconds       <= '0;
            shadowHours   <= '0;
            shadowMinutes <= '0;
            shadowSeconds <= '0;
            propagate     <= 1'b0;
            timeout       <= 1'b0;
            idleCnt       <= '0;
        end else begin
            setHist   <= set;
            propagate <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    hours   <= cur_hours;
                    minutes <= cur_minutes;
                    seconds <= curSec;
                    idleCnt <= '0;
                    if (setPress) begin
                        shadowHours   <= cur_hours;
                        shadowMinutes <= cur_minutes;
                        shadowSeconds <= curSec;
                        state         <= ST_HOUR;
                    end
                end
                default: begin
                    if (activity || timeoutHit) begin
                        idleCnt <= '0;
                    end else begin
                        idleCnt <= idleCnt + TW'(1);
                    end

                    if (setPress) begin
                        case (state)
                            ST_HOUR: state <= ST_MIN;
                            ST_MIN: begin
                                if (ENABLE_SEC != 0) begin
                                    state <= ST_SEC;
                                end else begin
                                    state     <= ST_IDLE;
                                    propagate <= 1'b1;
                                end
                            end
                            default: begin
                                state     <= ST_IDLE;
                                propagate <= 1'b1;
                            end
                        endcase
                    end else if (timeoutHit) begin
                        hours   <= shadowHours;
                        minutes <= shadowMinutes;
                        seconds <= shadowSeconds;
                        state   <= ST_IDLE;
                        timeout <= 1'b1;
                    end else if (upStep || downStep) begin
                        case (state)
                            ST_HOUR: hours <= HW'(upStep ? wrap_inc(6'(hours), HOURS_MOD)
                                                         : wrap_dec(6'(hours), HOURS_MOD));
                            ST_MIN:  minutes <= upStep ? wrap_inc(minutes, MIN_MOD)
                                                       : wrap_dec(minutes, MIN_MOD);
                            ST_SEC:  seconds <= upStep ? wrap_inc(seconds, SEC_MOD)
                                                       : wrap_dec(seconds, SEC_MOD);
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Parametrised successor to the 24-hour set controller. A set/up/down button FSM edits the hours, minutes and optional seconds fields of the wall clock.
- Hour modulus is configurable (24 or 12).
- Editing starts from a snapshot of the running time.
- Held up/down buttons auto-repeat.
- An idle timeout aborts the edit and restores the snapshot.
- Sits between the debounced button synchronisers and the timekeeping counter, which loads the edited fields on `propagate`.

Parameters:
- HOURS_MOD, 24, hour field modulus (24 gives 0..23, 12 gives 0..11).
- ENABLE_SEC, 1, 1 adds a SEC edit state; 0 skips it and holds seconds at 0.
- REPEAT_DELAY, 50_000_000, cycles a button is held before the first auto-repeat step.
- REPEAT_PERIOD, 10_000_000, cycles between later auto-repeat steps.
- TIMEOUT_CYCLES, 500_000_000, idle cycles in any edit state before abort; 0 disables the timeout.
- HW, $clog2(HOURS_MOD), hours width (derived; do not override).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- set  in  1  set button, debounced and synchronous to clk.
- up  in  1  increment button.
- down  in  1  decrement button.
- cur_hours  in  HW  running-clock hours, snapshotted on edit entry.
- cur_minutes  in  6  running-clock minutes.
- cur_seconds  in  6  running-clock seconds.
- hours  out  HW  edited hours.
- minutes  out  6  edited minutes.
- seconds  out  6  edited seconds.
- propagate  out  1  one-cycle pulse: commit the edited fields.
- timeout  out  1  one-cycle pulse: edit aborted.
- currentState  out  2  IDLE=0, HOUR=1, MIN=2, SEC=3.

Behaviour:
- Reset: state IDLE; hours/minutes/seconds 0; propagate and timeout 0; repeat and timeout counters 0. Button history registers are set to 1, so a button held through reset does not act until it is released and pressed again.
- Press: input sampled high while its history bit is low. The action takes effect on that same rising edge. There is no extra latency.
- IDLE:
  - hours/minutes/seconds follow the cur_* inputs every cycle.
  - up/down are ignored.
  - set press: snapshot cur_* into the shadow registers and go to HOUR.
- HOUR, set press: go to MIN.
- MIN, set press: go to SEC if ENABLE_SEC=1; else go to IDLE and pulse propagate.
- SEC, set press: go to IDLE and pulse propagate.
- Fields are frozen while not in IDLE. propagate is asserted the cycle after the edge on which the final set press is sampled, and only for that cycle.
- up step: the active field +1, wrapping. hours goes HOURS_MOD-1 to 0; minutes and seconds go 59 to 0.
- down step: the active field -1, wrapping. hours goes 0 to HOURS_MOD-1; minutes and seconds go 0 to 59.
- Auto-repeat:
  - A step fires on the press.
  - While the button stays high, a further step fires after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - Release clears the repeat counter.
- Simultaneous events:
  - set press in the same cycle as up/down activity: set wins, no step is applied, and the repeat counters clear.
  - up and down both high: no step; both repeat counters are held at 0.
- Timeout:
  - Any press or auto-repeat step clears the idle counter.
  - When the counter reaches TIMEOUT_CYCLES in an edit state: restore the fields from the shadow registers, go to IDLE, pulse timeout, and do not pulse propagate.
- reset asserted mid-edit: immediate return to the reset values. No propagate, no timeout pulse.
- ENABLE_SEC=0: the SEC encoding is unreachable and seconds reads 0 in every state, IDLE included.

Decomposition:
- Package time_set_pkg holds:
  - the state encoding constants ST_IDLE, ST_HOUR, ST_MIN, ST_SEC;
  - MIN_MOD=60 and SEC_MOD=60;
  - a wrap_inc/wrap_dec helper function taking a modulus argument.
- Sub-module button_repeat (params DELAY, PERIOD; ports clk, reset, btn, step): holds the history register, the press detect and the repeat counter. Instantiate it twice, for up and down.
- The set button uses edge detect only, with no repeat.

Test Plan:
Bench parameters: REPEAT_DELAY=4, REPEAT_PERIOD=2, TIMEOUT_CYCLES=20, cur=13:45:07.
1. Basic edit:
   - set, up, set, down, set, set (1 cycle each, 2 cycles apart).
   - States go 1, 2, 3, 0.
   - Result 14:44:07; propagate high for exactly one cycle on exit.
2. Wrap:
   - cur=23:59:00; in HOUR press up, then in MIN press up → 00:00.
   - Press down in each field → 23:59.
   - With HOURS_MOD=12, cur hours 11: up → 0.
3. Auto-repeat:
   - In MIN from 45, hold up for 10 cycles.
   - Steps occur at cycles 0, 4, 6, 8 → minutes 49.
   - Release, then a fresh press → 50.
4. Timeout:
   - Enter HOUR, press up (14), then idle 20 cycles.
   - timeout pulses once; state 0; fields restored to 13:45:07; propagate never asserted.
5. Conflicts:
   - set and up high in the same cycle in HOUR → state MIN, hours unchanged.
   - up and down held together → no change.
6. Reset:
   - reset mid-edit in MIN → state 0, fields 0, propagate 0.
   - up held through the reset release → no step until it is released and pressed again.
   - ENABLE_SEC=0: third set returns to IDLE with propagate; seconds output 0.
